// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - 8-way arbiter with registered one-hot grant and bounded hold time
// Optional build macro: ARB_FIXED_PRIO_EN (fixed MSB-first priority instead of round-robin)

module onehot_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic       busy,
    output logic       grant_end,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Hold limit; with MAX_HOLD == 0 the counter simply saturates at all-ones.
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD != 0) ? HOLD_LIM : {CNT_W{1'b1}};

    state_t           state;
    logic [2:0]       gidx;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       sel;
    logic             req_g;
    logic             limit_hit;

`ifndef ARB_FIXED_PRIO_EN
    logic [2:0]       ptr;
`endif

    assign req_g     = req[gidx];
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: highest set request bit wins, matching the encoder's MSB-first precedence.
    always_comb begin
        sel = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (req[k]) begin
                sel = 3'(k);
            end
        end
    end
`else
    // Round-robin: first set request bit found scanning upward from ptr, wrapping mod 8.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        sel   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    // Arbitration FSM: IDLE picks a winner, GRANT holds it, GAP forces one zero cycle before IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 8'h00;
            busy      <= 1'b0;
            grant_end <= 1'b0;
            timeout   <= 1'b0;
            gidx      <= 3'd0;
            hold_cnt  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr       <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    grant_end <= 1'b0;
                    timeout   <= 1'b0;
                    if (|req) begin
                        grant    <= 8'h01 << sel;
                        gidx     <= sel;
                        busy     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped request takes precedence, so a tie with the limit is a normal release.
                    if (!req_g || limit_hit) begin
                        grant     <= 8'h00;
                        busy      <= 1'b0;
                        grant_end <= 1'b1;
                        timeout   <= limit_hit && req_g;
                        hold_cnt  <= '0;
`ifndef ARB_FIXED_PRIO_EN
                        ptr       <= gidx + 3'd1;
`endif
                        state     <= GAP;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    grant_end <= 1'b0;
                    timeout   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    grant     <= 8'h00;
                    busy      <= 1'b0;
                    grant_end <= 1'b0;
                    timeout   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb/tb_onehot_rr_arbiter.sv - self-checking bench for onehot_rr_arbiter

module tb_onehot_rr_arbiter;

    localparam int MAXH  = 4;
    localparam int CW    = 3;
    localparam int STARV = 8 * (MAXH + 2);

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic       busy;
    logic       grant_end;
    logic       timeout;

    int checks;
    int errors;

    // Reference model state: who holds the resource, for how long, and forced zero cycles left.
    int         m_cur;
    int         m_held;
    int         m_zero;
    int         m_ptr;
    logic [7:0] exp_grant;
    logic       exp_end;
    logic       exp_to;

    onehot_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .busy      (busy),
        .grant_end (grant_end),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cur     = -1;
        m_held    = 0;
        m_zero    = 0;
        m_ptr     = 0;
        exp_grant = 8'h00;
        exp_end   = 1'b0;
        exp_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int pick;
        exp_end = 1'b0;
        exp_to  = 1'b0;
        if (m_cur >= 0) begin
            if (!r[m_cur] || (MAXH != 0 && m_held == MAXH)) begin
                exp_end = 1'b1;
                exp_to  = r[m_cur];
                m_ptr   = (m_cur + 1) % 8;
                m_cur   = -1;
                m_zero  = 1;
            end else if (m_held < MAXH) begin
                m_held = m_held + 1;
            end
        end else if (m_zero > 0) begin
            m_zero = m_zero - 1;
        end else if (r != 8'h00) begin
            pick = -1;
`ifdef ARB_FIXED_PRIO_EN
            for (int i = 7; i >= 0; i--)
                if (pick < 0 && r[i]) pick = i;
`else
            for (int i = 0; i < 8; i++)
                if (pick < 0 && r[(m_ptr + i) % 8]) pick = (m_ptr + i) % 8;
`endif
            m_cur  = pick;
            m_held = 1;
        end
        exp_grant = (m_cur >= 0) ? (8'h01 << m_cur) : 8'h00;
    endtask

    // Apply r for the next rising edge, then return at the following falling edge.
    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 8'h00 || busy !== 1'b0 || grant_end !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%h busy=%b end=%b to=%b, required 00 0 0 0", grant, busy, grant_end, timeout);
        end
        step(8'h10);
        checks++;
        if (grant !== 8'h10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant: grant=%h busy=%b, required 10 1", grant, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 8'h00 || busy !== 1'b0 || grant_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: grant=%h busy=%b end=%b, required 00 0 0", grant, busy, grant_end);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (grant_end !== 1'b0 || grant !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_end: grant=%h end=%b, required 00 0", grant, grant_end);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h01);
        checks++;
        if (grant !== 8'h01 || grant !== exp_grant) begin
            errors++;
            $display("FAIL reset_regrant: grant=%h, required 01", grant);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 3; i++) step(8'h00);
        for (int i = 0; i < 3; i++) begin
            step(8'h08);
            checks++;
            if (grant !== 8'h08 || busy !== 1'b1 || grant !== exp_grant) begin
                errors++;
                $display("FAIL single_hold%0d: grant=%h busy=%b, required 08 1", i, grant, busy);
            end
        end
        step(8'h00);
        checks++;
        if (grant !== 8'h00 || grant_end !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%h end=%b to=%b busy=%b, required 00 1 0 0", grant, grant_end, timeout, busy);
        end
        step(8'h08);
        checks++;
        if (grant !== 8'h00 || grant_end !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: grant=%h end=%b, required 00 0", grant, grant_end);
        end
        step(8'h08);
        checks++;
        if (grant !== 8'h08) begin
            errors++;
            $display("FAIL single_regrant: grant=%h, required 08", grant);
        end
        step(8'h00);
        step(8'h00);
    endtask

    task automatic test_tie();
        step(8'h00);
        for (int i = 0; i < MAXH; i++) step(8'h02);
        step(8'h00);
        checks++;
        if (grant !== 8'h00 || grant_end !== 1'b1 || timeout !== 1'b0 || exp_to !== 1'b0) begin
            errors++;
            $display("FAIL tie_release: grant=%h end=%b to=%b, required 00 1 0", grant, grant_end, timeout);
        end
        step(8'h00);
        step(8'h00);
    endtask

    task automatic test_round_robin();
        logic [7:0] seq [3];
`ifdef ARB_FIXED_PRIO_EN
        seq[0] = 8'h80; seq[1] = 8'h80; seq[2] = 8'h80;
`else
        seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'h01;
`endif
        do_reset();
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < MAXH; c++) begin
                step(8'h81);
                checks++;
                if (grant !== seq[g] || grant !== exp_grant) begin
                    errors++;
                    $display("FAIL rr_grant%0d_c%0d: grant=%h, required %h", g, c, grant, seq[g]);
                end
            end
            step(8'h81);
            checks++;
            if (grant !== 8'h00 || grant_end !== 1'b1 || timeout !== 1'b1) begin
                errors++;
                $display("FAIL rr_timeout%0d: grant=%h end=%b to=%b, required 00 1 1", g, grant, grant_end, timeout);
            end
            step(8'h81);
            checks++;
            if (grant !== 8'h00 || grant_end !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap%0d: grant=%h end=%b to=%b, required 00 0 0", g, grant, grant_end, timeout);
            end
        end
        step(8'h00);
        step(8'h00);
        step(8'h00);
    endtask

`ifdef ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int c = 0; c < MAXH; c++) begin
                step(8'h24);
                checks++;
                if (grant !== 8'h20) begin
                    errors++;
                    $display("FAIL fixed_grant_r%0d_c%0d: grant=%h, required 20", round, c, grant);
                end
            end
            step(8'h24);
            step(8'h24);
        end
        step(8'h00);
        step(8'h00);
    endtask
`endif

    task automatic test_random();
        int         waitc [8];
        logic [7:0] r;
        for (int i = 0; i < 8; i++) waitc[i] = 0;
        r = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom | $urandom);
            step(r);
            checks++;
            if (grant !== exp_grant || busy !== (exp_grant != 8'h00) ||
                grant_end !== exp_end || timeout !== exp_to) begin
                errors++;
                $display("FAIL random_cycle%0d: grant=%h busy=%b end=%b to=%b, required %h %b %b %b",
                         n, grant, busy, grant_end, timeout, exp_grant, exp_grant != 8'h00, exp_end, exp_to);
            end
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("FAIL random_onehot%0d: grant=%h, required one-hot or 00", n, grant);
            end
            for (int i = 0; i < 8; i++) begin
                if (r[i] && grant !== (8'h01 << i)) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > STARV) begin
                    checks++;
                    errors++;
                    $display("FAIL random_starve%0d: requester %0d waited %0d, required <= %0d", n, i, waitc[i], STARV);
                    waitc[i] = 0;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder. Arbitrates 8 request lines and drives a registered, strictly one-hot (or all-zero) 8-bit grant vector.
- The grant vector is wired directly to the encoder's din, so the encoder only ever sees legal one-hot codes or zero.
- Round-robin by default, with a bounded hold time so one requester cannot starve the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a grant may be held; 0 disables the timeout.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; req[i] held high while requester i wants the resource.
- grant  output  8  registered grant; one-hot or 8'h00; feeds encoder din.
- busy  output  1  high while any grant bit is set (equals |grant, registered).
- grant_end  output  1  one-cycle pulse on the cycle grant returns to 0.
- timeout  output  1  one-cycle pulse coincident with grant_end when the release was forced by MAX_HOLD.

Behaviour:
- Reset (async, rst_n=0): grant=8'h00, busy=0, grant_end=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE. Takes effect immediately, including mid-grant; no grant_end pulse is generated by reset.
- States: IDLE, GRANT, GAP.
- IDLE: if req==0, stay. Otherwise select the first set bit scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (wraps mod 8). At the edge: grant<=onehot(sel), busy<=1, hold_cnt<=1, state<=GRANT. Latency from req sampled to grant visible: 1 cycle.
- GRANT: grant held stable; g is the granted index.
  - Release when req[g]==0 (normal), or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD (forced).
  - On release, at the edge: grant<=0, busy<=0, grant_end<=1, timeout<=forced&&req[g], ptr<=g+1 mod 8 (7 wraps to 0), state<=GAP.
  - Otherwise hold_cnt<=hold_cnt+1, saturating at MAX_HOLD.
  - If req[g] drops in the same cycle the limit is reached, it counts as a normal release and timeout=0.
- GAP: grant=0 for exactly one cycle; grant_end and timeout return to 0; state<=IDLE. A new grant appears 2 cycles after the falling grant edge at the earliest, which keeps the encoder's zero code visible between grants.
- Changes to req bits other than g during GRANT are ignored. Requests that assert and drop entirely while the arbiter is in GAP are never granted.
- grant never has more than one bit set, in any state or at any time.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: ptr is unused and held at 0; selection is fixed priority with bit 7 highest, down to bit 0 lowest (matches the encoder's MSB-first precedence). MAX_HOLD timeout still applies.
- Undefined: round-robin as described above.

Test Plan:
- Reset mid-grant: grant=8'h10, assert rst_n=0 -> grant=8'h00, busy=0 immediately; no grant_end pulse; after release, req=8'h01 -> grant=8'h01 one cycle later.
- Single request: req=8'h08 held 3 cycles then 0 -> grant=8'h08 for 3 cycles starting 1 cycle after req; grant_end=1 and timeout=0 on the first zero cycle; grant=0 for 2 cycles.
- Round-robin wrap: ptr=0, req=8'h81 held continuously with MAX_HOLD=4 -> grant sequence 8'h01, 8'h80, 8'h01, each held 4 cycles with timeout=1 on every release, 2-cycle zero gap between grants.
- Timeout vs. drop tie: req[g] falls in the same cycle hold_cnt reaches MAX_HOLD -> grant_end=1, timeout=0.
- ARB_FIXED_PRIO_EN defined, req=8'h24 -> grant=8'h20; after release with req still 8'h24 -> grant=8'h20 again (no rotation).
- Randomised req over 10k cycles -> grant is always 0 or a power of two, and no requester that stays asserted waits more than 8*(MAX_HOLD+2) cycles.
